acf_sum_generator: RTL and testbench
====================================

# acf_sum_generator

Streaming autocorrelation engine that produces the integer lag sums R[0]..R[ORDER] of each fixed-size block of signed PCM samples. It is the transmitter side of the 43-bit ACF stream consumed by the ACF normalising divider: it emits exactly ORDER+1 consecutive valid words per block, lag 0 first, with no back-pressure. It sits between the sample framer and the divider in the LPC analysis chain.

## Interface
- ORDER, 12, highest lag computed; ORDER+1 words are emitted per block
- BLOCK_SIZE, 4096, samples per block; must be at least ORDER+4
- iClock  in  1  rising-edge clock
- iReset_n  in  1  asynchronous, active-low reset
- iEnable  in  1  global clock enable; when low, all state holds, including oValid and oACF
- iSample  in  16  signed PCM sample
- iValid  in  1  iSample is accepted on this edge when iEnable is high
- oACF  out  43  signed lag sum R[k]
- oValid  out  1  oACF is valid this cycle

## Operation
- Delay line: ORDER registers hold x[n-1]..x[n-ORDER]. It is cleared at reset and at every block boundary, so history is zero at the start of each block.
- Per accepted sample x[n], lane k (0..ORDER) forms the product x[n]*x[n-k], a 32-bit signed value registered in stage 1. Stage 2 adds it into a 44-bit signed accumulator acc[k].
- Sample counter: 0..BLOCK_SIZE-1, incremented on each accepted sample. Acceptance at count BLOCK_SIZE-1 marks the last sample:
  - the counter wraps to 0;
  - the delay line shifts in zeros instead of x[n].
- Commit: when the last product reaches stage 2, each shadow[k] is loaded with acc[k]+prod[k] and acc[k] is cleared to 0 on the same edge. The serializer then starts.
- Serializer states:
  - IDLE: oValid=0. Go to SEND on commit.
  - SEND: an index runs 0..ORDER; oACF is driven from shadow[index] and oValid=1. Return to IDLE after index ORDER.
- Output saturation: 44-bit values are clamped to the range -2^42 .. 2^42-1 before driving oACF.
- The next block's samples may arrive on the cycle after the last sample. Their accumulation proceeds in acc[] while the shadow bank is being sent. BLOCK_SIZE ≥ ORDER+4 guarantees the previous SEND has finished before the next commit.
- Gaps: iValid may drop at any point; the counter and pipeline advance only on accepted samples. Pipeline stage bubbles carry a valid bit and add nothing to the accumulators.

## Timing
- Reset values: oValid=0, oACF=0, counter=0, delay line=0, acc=0, shadow=0, serializer in IDLE.
- Reset mid-block or mid-SEND: asynchronous abort. The partial block and any unsent words are discarded. The first sample after reset is x[0] of a new block.
- Latency, counted in iEnable-high cycles: last sample accepted at edge T → stage 1 at T+1 → commit at T+2 → oValid=1 with R[0] from edge T+3. R[ORDER] is driven from edge T+3+ORDER, and oValid returns to 0 from edge T+4+ORDER.
- oValid is high for exactly ORDER+1 consecutive iEnable-high cycles per block. There are no gaps inside a burst.
- iEnable low freezes all registers. Bursts stretch but are never reordered or dropped.

## Configuration
- ACFGEN_SILENT_GUARD_EN:
  - Defined: a block whose saturated R[0]==0 (all-zero input) is emitted as R[0]=1 and R[1..ORDER]=0. This protects the downstream divider from a zero denominator.
  - Undefined: all-zero sums are emitted exactly as computed.

## Test plan
- ORDER=2, BLOCK_SIZE=8, eight samples of 1 → oACF 8, 7, 6 on three consecutive cycles starting 3 cycles after the last sample.
- ORDER=2, BLOCK_SIZE=8, samples alternating +100/-100 → 80000, -70000, 60000.
- Defaults, 4096 samples of -32768 → R[0]=4398046511103 (saturated), R[1]=4396972769280, R[12]=4385161609216.
- ORDER=2, BLOCK_SIZE=8, block of all 1 followed immediately by block of all 2, iValid held high throughout → bursts 8,7,6 then 32,28,24. Confirms no history leaks across blocks.
- iReset_n pulsed low after 5 samples of a block, then 8 samples of 3 → single burst 72, 63, 54; nothing is emitted for the aborted block.
- ORDER=2, BLOCK_SIZE=8, eight zeros → 1, 0, 0 with ACFGEN_SILENT_GUARD_EN defined; 0, 0, 0 without it. Random iEnable drops during the same run → identical values, with bursts stretched.

Source files
------------

// File: rtl/acf_sum_generator.sv
// acf_sum_generator: streaming block autocorrelation R[0..ORDER] with a burst serializer.
// Define ACFGEN_SILENT_GUARD_EN to emit R[0]=1 for an all-zero block.
module acf_sum_generator #(
  parameter int ORDER      = 12,
  parameter int BLOCK_SIZE = 4096
) (
  input  logic               iClock,
  input  logic               iReset_n,
  input  logic               iEnable,
  input  logic signed [15:0] iSample,
  input  logic               iValid,
  output logic signed [42:0] oACF,
  output logic               oValid
);
  localparam int CW = $clog2(BLOCK_SIZE);
  localparam int IW = $clog2(ORDER + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(BLOCK_SIZE - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(ORDER);
  typedef enum logic {IDLE, SEND} state_t;

  logic [CW-1:0]      cnt_q;
  logic               clr_q, s0_vld_q, s0_last_q, s1_vld_q, s1_last_q;
  logic signed [15:0] win_q  [ORDER+1];
  logic signed [31:0] prod_q [ORDER+1];
  logic signed [43:0] acc_q  [ORDER+1];
  logic signed [43:0] shad_q [ORDER+1];
  logic signed [43:0] sum_d  [ORDER+1];
  logic signed [43:0] sel_d;
  logic signed [42:0] word_d;
  state_t             st_q;
  logic [IW-1:0]      idx_q;

  always_comb begin
    for (int k = 0; k <= ORDER; k++) sum_d[k] = acc_q[k] + 44'(prod_q[k]);
    sel_d  = shad_q[idx_q];
    word_d = (sel_d[43] != sel_d[42]) ? (sel_d[43] ? {1'b1, 42'd0} : {1'b0, {42{1'b1}}}) : sel_d[42:0];
`ifdef ACFGEN_SILENT_GUARD_EN
    if (shad_q[0] == '0) word_d = (idx_q == '0) ? 43'sd1 : '0;
`endif
  end

  // win_q[0] is the newest sample, win_q[k] its lag-k partner; history is zeroed after a block's last sample.
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      cnt_q     <= '0;
      clr_q     <= 1'b0;
      s0_vld_q  <= 1'b0;
      s0_last_q <= 1'b0;
      s1_vld_q  <= 1'b0;
      s1_last_q <= 1'b0;
      for (int k = 0; k <= ORDER; k++) begin
        win_q[k]  <= '0;
        prod_q[k] <= '0;
        acc_q[k]  <= '0;
        shad_q[k] <= '0;
      end
      st_q   <= IDLE;
      idx_q  <= '0;
      oACF   <= '0;
      oValid <= 1'b0;
    end else if (iEnable) begin
      s0_vld_q  <= iValid;
      s0_last_q <= iValid && (cnt_q == CNT_LAST);
      if (iValid) begin
        cnt_q    <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
        clr_q    <= cnt_q == CNT_LAST;
        win_q[0] <= iSample;
        for (int k = 1; k <= ORDER; k++) win_q[k] <= clr_q ? '0 : win_q[k-1];
      end
      s1_vld_q  <= s0_vld_q;
      s1_last_q <= s0_vld_q && s0_last_q;
      if (s0_vld_q)
        for (int k = 0; k <= ORDER; k++) prod_q[k] <= 32'(win_q[0]) * 32'(win_q[k]);
      if (s1_vld_q)
        for (int k = 0; k <= ORDER; k++) begin
          acc_q[k] <= s1_last_q ? '0 : sum_d[k];
          if (s1_last_q) shad_q[k] <= sum_d[k];
        end
      if (st_q == IDLE) begin
        oValid <= 1'b0;
        idx_q  <= '0;
        if (s1_vld_q && s1_last_q) st_q <= SEND;
      end else begin
        oValid <= 1'b1;
        oACF   <= word_d;
        idx_q  <= idx_q + 1'b1;
        if (idx_q == IDX_LAST) st_q <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_acf_sum_generator.sv
// tb_acf_sum_generator: randomized checks of acf_sum_generator against a direct lag-sum model.
// Expectations follow ACFGEN_SILENT_GUARD_EN when it is defined for the build.
module tb_acf_sum_generator;
  logic clk = 1'b0, rst_n = 1'b0, en = 1'b1, vld = 1'b0, vld1 = 1'b0;
  logic signed [15:0] smp = '0, smp1 = '0;
  logic signed [42:0] acf0, acf1;
  logic val0, val1;
  int checks = 0, errors = 0, cyc = 0, t_last = 0;
  longint blk [4096];
  longint exp0_q[$], exp1_q[$], got0_q[$], got1_q[$];
  int got0_t[$];
  localparam longint MAXV = (longint'(1) <<< 42) - 1;
  localparam longint MINV = -(longint'(1) <<< 42);
  localparam longint PAD  = 64'h7fff_ffff_ffff_ffff;

  acf_sum_generator #(.ORDER(2), .BLOCK_SIZE(8)) u_small (
    .iClock(clk), .iReset_n(rst_n), .iEnable(en), .iSample(smp), .iValid(vld),
    .oACF(acf0), .oValid(val0));
  acf_sum_generator u_big (
    .iClock(clk), .iReset_n(rst_n), .iEnable(en), .iSample(smp1), .iValid(vld1),
    .oACF(acf1), .oValid(val1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // en seen at a falling edge is the enable that applies to the coming rising edge
  always @(negedge clk) if (en) begin
    if (val0) begin got0_q.push_back(longint'(acf0)); got0_t.push_back(cyc); end
    if (val1) got1_q.push_back(longint'(acf1));
  end

  function automatic void expect_block(input int n, input int ord, input bit big);
    longint r [13];
    for (int k = 0; k <= ord; k++) begin
      r[k] = 0;
      for (int i = k; i < n; i++) r[k] += blk[i] * blk[i-k];
      r[k] = (r[k] > MAXV) ? MAXV : (r[k] < MINV) ? MINV : r[k];
    end
`ifdef ACFGEN_SILENT_GUARD_EN
    if (r[0] == 0) begin
      r[0] = 1;
      for (int k = 1; k <= ord; k++) r[k] = 0;
    end
`endif
    for (int k = 0; k <= ord; k++)
      if (big) exp1_q.push_back(r[k]); else exp0_q.push_back(r[k]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_q();
    exp0_q.delete(); exp1_q.delete(); got0_q.delete(); got1_q.delete(); got0_t.delete();
  endtask

  task automatic feed(input longint s, input bit big, input bit jitter);
    while (jitter && $urandom_range(0, 2) == 0) begin
      en = 1'($urandom_range(0, 1));
      smp = 16'($urandom);
      if (big) vld1 = !en && $urandom_range(0, 1) == 1; else vld = !en && $urandom_range(0, 1) == 1;
      tick();
    end
    en = 1'b1;
    if (big) begin vld1 = 1'b1; smp1 = 16'(s); end
    else begin vld = 1'b1; smp = 16'(s); end
    tick();
    vld = 1'b0;
    vld1 = 1'b0;
    t_last = cyc;
  endtask

  task automatic wait_words(input int n, input bit big, input bit jitter, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      if (jitter) en = 1'($urandom_range(0, 1));
      tick();
      ok = (big ? got1_q.size() : got0_q.size()) >= n;
    end
    en = 1'b1;
  endtask

  function automatic longint rnd_sample();
    return longint'($urandom_range(0, 65535)) - 32768;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; en = 1'b1; vld = 1'b0; vld1 = 1'b0;
    repeat (3) tick();
    checks++; if (val0 !== 1'b0) begin errors++; $display("FAIL reset_valid_small got %b want 0", val0); end
    checks++; if (acf0 !== '0) begin errors++; $display("FAIL reset_acf_small got %0d want 0", acf0); end
    checks++; if (val1 !== 1'b0) begin errors++; $display("FAIL reset_valid_big got %b want 0", val1); end
    checks++; if (acf1 !== '0) begin errors++; $display("FAIL reset_acf_big got %0d want 0", acf1); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_ones();
    bit ok;
    clear_q();
    for (int i = 0; i < 8; i++) begin blk[i] = 1; feed(1, 0, 0); end
    expect_block(8, 2, 0);
    wait_words(3, 0, 0, ok);
    repeat (2) tick();
    checks++; if (!ok || got0_q.size() != 3) begin errors++; $display("FAIL ones_count got %0d want 3", got0_q.size()); end
    while (got0_q.size() < 3) begin got0_q.push_back(PAD); got0_t.push_back(-1); end
    for (int i = 0; i < 3; i++) begin
      checks++; if (got0_q[i] !== exp0_q[i]) begin errors++; $display("FAIL ones_word%0d got %0d want %0d", i, got0_q[i], exp0_q[i]); end
    end
    checks++; if (got0_t[0] != t_last + 3) begin errors++; $display("FAIL ones_first_latency got %0d want %0d", got0_t[0] - t_last, 3); end
    checks++; if (got0_t[2] != t_last + 5) begin errors++; $display("FAIL ones_last_latency got %0d want %0d", got0_t[2] - t_last, 5); end
    checks++; if (val0 !== 1'b0) begin errors++; $display("FAIL ones_valid_drop got %b want 0", val0); end
  endtask

  task automatic test_alternating();
    bit ok;
    clear_q();
    for (int i = 0; i < 8; i++) begin blk[i] = (i % 2 == 0) ? 100 : -100; feed(blk[i], 0, 0); end
    expect_block(8, 2, 0);
    wait_words(3, 0, 0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL alt_count got %0d want 3", got0_q.size()); end
    while (got0_q.size() < 3) got0_q.push_back(PAD);
    for (int i = 0; i < 3; i++) begin
      checks++; if (got0_q[i] !== exp0_q[i]) begin errors++; $display("FAIL alt_word%0d got %0d want %0d", i, got0_q[i], exp0_q[i]); end
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    clear_q();
    for (int b = 1; b <= 2; b++) begin
      for (int i = 0; i < 8; i++) begin blk[i] = b; feed(b, 0, 0); end
      expect_block(8, 2, 0);
    end
    wait_words(6, 0, 0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_count got %0d want 6", got0_q.size()); end
    while (got0_q.size() < 6) begin got0_q.push_back(PAD); got0_t.push_back(-1); end
    for (int i = 0; i < 6; i++) begin
      checks++; if (got0_q[i] !== exp0_q[i]) begin errors++; $display("FAIL b2b_word%0d got %0d want %0d", i, got0_q[i], exp0_q[i]); end
    end
    checks++; if (got0_t[3] != t_last + 3) begin errors++; $display("FAIL b2b_second_latency got %0d want 3", got0_t[3] - t_last); end
  endtask

  task automatic test_reset_abort();
    bit ok;
    clear_q();
    for (int i = 0; i < 5; i++) feed(rnd_sample(), 0, 0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin blk[i] = 3; feed(3, 0, 0); end
    expect_block(8, 2, 0);
    wait_words(3, 0, 0, ok);
    repeat (12) tick();
    checks++; if (got0_q.size() != 3) begin errors++; $display("FAIL abort_count got %0d want 3", got0_q.size()); end
    while (got0_q.size() < 3) got0_q.push_back(PAD);
    for (int i = 0; i < 3; i++) begin
      checks++; if (got0_q[i] !== exp0_q[i]) begin errors++; $display("FAIL abort_word%0d got %0d want %0d", i, got0_q[i], exp0_q[i]); end
    end
  endtask

  task automatic test_zeros(input bit jitter);
    bit ok;
    clear_q();
    for (int i = 0; i < 8; i++) begin blk[i] = 0; feed(0, 0, jitter); end
    expect_block(8, 2, 0);
    wait_words(3, 0, jitter, ok);
    repeat (8) tick();
    checks++; if (got0_q.size() != 3) begin errors++; $display("FAIL zeros_count jitter=%0d got %0d want 3", jitter, got0_q.size()); end
    while (got0_q.size() < 3) got0_q.push_back(PAD);
    for (int i = 0; i < 3; i++) begin
      checks++; if (got0_q[i] !== exp0_q[i]) begin errors++; $display("FAIL zeros_word%0d jitter=%0d got %0d want %0d", i, jitter, got0_q[i], exp0_q[i]); end
    end
  endtask

  task automatic test_random_gaps();
    bit ok;
    clear_q();
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < 8; i++) begin blk[i] = rnd_sample(); feed(blk[i], 0, 1); end
      expect_block(8, 2, 0);
    end
    wait_words(18, 0, 1, ok);
    repeat (8) tick();
    checks++; if (got0_q.size() != 18) begin errors++; $display("FAIL rand_count got %0d want 18", got0_q.size()); end
    while (got0_q.size() < 18) got0_q.push_back(PAD);
    for (int i = 0; i < 18; i++) begin
      checks++; if (got0_q[i] !== exp0_q[i]) begin errors++; $display("FAIL rand_word%0d got %0d want %0d", i, got0_q[i], exp0_q[i]); end
    end
  endtask

  task automatic test_saturation();
    bit ok;
    clear_q();
    for (int i = 0; i < 4096; i++) begin blk[i] = -32768; feed(-32768, 1, 0); end
    expect_block(4096, 12, 1);
    wait_words(13, 1, 0, ok);
    repeat (4) tick();
    checks++; if (got1_q.size() != 13) begin errors++; $display("FAIL sat_count got %0d want 13", got1_q.size()); end
    while (got1_q.size() < 13) got1_q.push_back(PAD);
    for (int i = 0; i < 13; i++) begin
      checks++; if (got1_q[i] !== exp1_q[i]) begin errors++; $display("FAIL sat_word%0d got %0d want %0d", i, got1_q[i], exp1_q[i]); end
    end
  endtask

  initial begin
    test_reset();
    test_ones();
    test_alternating();
    test_back_to_back();
    test_reset_abort();
    test_zeros(1'b0);
    test_zeros(1'b1);
    test_random_gaps();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL global_timeout got running want finished");
    $fatal(1);
  end
endmodule
